data_island_scheduler: RTL and testbench

- Upstream controller for the data-island packet serializer. It accepts HDMI packets over a valid/ready interface and decides when a data island fits inside horizontal/vertical blanking.
- Sequences the island: control-period preamble, leading guard band, 1..MAX_PACKETS packets, trailing guard band, tail control.
- Drives the serializer's packet-start strobe and holds packet contents stable.
- Its period code steers the downstream TMDS/TERC4 channel mux.

---
 rtl/data_island_scheduler_pkg.sv | 28 ++
 rtl/data_island_scheduler_budget_check.sv | 23 ++
 rtl/data_island_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_data_island_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_island_scheduler_pkg.sv
// Shared definitions for the HDMI data-island scheduler: period codes, preamble
// CTL pattern, packet length, FSM states and a saturating counter helper.
package data_island_scheduler_pkg;

    typedef enum logic [1:0] {
        PERIOD_CONTROL  = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_DATA     = 2'd3
    } period_e;

    localparam logic [3:0] CTL_PREAMBLE = 4'b1010;
    localparam int         PACKET_LEN   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LEAD_GUARD,
        ST_PACKET,
        ST_TRAIL_GUARD,
        ST_TAIL
    } state_e;

    function automatic logic [15:0] satInc16(input logic [15:0] value, input logic inc);
        return (inc && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/data_island_scheduler_budget_check.sv
// Combinational blanking-budget test: does a whole new island (startFits) or one
// more packet plus its closing guard and tail (contFits) fit in the remaining blank?
module island_budget_check
    import data_island_scheduler_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int TAIL_LEN     = 4
) (
    input  logic [11:0] blankRemaining_i,
    output logic        startFits_o,
    output logic        contFits_o
);

    localparam int START_BUDGET = PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN + TAIL_LEN;
    localparam int CONT_BUDGET  = PACKET_LEN + GUARD_LEN + TAIL_LEN;

    always_comb begin
        startFits_o = (blankRemaining_i > 12'(START_BUDGET));
        contFits_o  = (blankRemaining_i > 12'(CONT_BUDGET));
    end

endmodule

// File: rtl/data_island_scheduler.sv
// Data-island scheduler: places preamble, guard bands and 1..MAX_PACKETS HDMI packets
// inside blanking. Define DATA_ISLAND_STATS_EN to add saturating island/packet/defer counters.
module data_island_scheduler
    import data_island_scheduler_pkg::*;
#(
    parameter int MAX_PACKETS  = 18,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int TAIL_LEN     = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        inBlank,
    input  logic [11:0] blankRemaining,
    input  logic        pktValid,
    output logic        pktReady,
    input  logic [23:0] pktHeader,
    input  logic [55:0] pktSubpacket0,
    input  logic [55:0] pktSubpacket1,
    input  logic [55:0] pktSubpacket2,
    input  logic [55:0] pktSubpacket3,
    output logic [1:0]  period,
    output logic [3:0]  ctl,
    output logic        isFirstPacketClock,
    output logic [23:0] header,
    output logic [55:0] subpacket0,
    output logic [55:0] subpacket1,
    output logic [55:0] subpacket2,
    output logic [55:0] subpacket3,
    output logic        islandOverrun
`ifdef DATA_ISLAND_STATS_EN
    ,
    output logic [15:0] islandCount,
    output logic [15:0] packetCount,
    output logic [15:0] deferCount
`endif
);

    localparam logic [7:0] PREAMBLE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] GUARD_LAST    = 8'(GUARD_LEN - 1);
    localparam logic [7:0] PACKET_LAST   = 8'(PACKET_LEN - 1);
    localparam logic [7:0] TAIL_LAST     = 8'(TAIL_LEN - 1);
    localparam logic [4:0] MAX_SENT      = 5'(MAX_PACKETS);

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [4:0]  sent_q, sent_d;
    logic [23:0] header_q;
    logic [55:0] subpacket0_q, subpacket1_q, subpacket2_q, subpacket3_q;
    logic        overrun_q;
    logic        startFits, contFits;
    logic        islandActive;

    island_budget_check #(
        .PREAMBLE_LEN (PREAMBLE_LEN),
        .GUARD_LEN    (GUARD_LEN),
        .TAIL_LEN     (TAIL_LEN)
    ) budgetCheck (
        .blankRemaining_i (blankRemaining),
        .startFits_o      (startFits),
        .contFits_o       (contFits)
    );

    // count_q times each phase; in ST_PACKET it is the 0..31 packet clock index.
    always_comb begin
        state_d            = state_q;
        count_d            = count_q;
        sent_d             = sent_q;
        pktReady           = 1'b0;
        period             = PERIOD_CONTROL;
        ctl                = '0;
        isFirstPacketClock = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sent_d  = '0;
                count_d = '0;
                if (inBlank && pktValid && startFits) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                period = PERIOD_PREAMBLE;
                ctl    = CTL_PREAMBLE;
                if (count_q == PREAMBLE_LAST) begin
                    state_d = ST_LEAD_GUARD;
                    count_d = '0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_LEAD_GUARD: begin
                period = PERIOD_GUARD;
                if (count_q == GUARD_LAST) begin
                    pktReady = 1'b1;
                    state_d  = ST_PACKET;
                    count_d  = '0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_PACKET: begin
                period             = PERIOD_DATA;
                isFirstPacketClock = (count_q == 8'd0);
                if (count_q == PACKET_LAST) begin
                    count_d = '0;
                    // Back-to-back continuation only if the next packet still fits in blanking.
                    if (pktValid && (sent_q < MAX_SENT) && inBlank && contFits) begin
                        pktReady = 1'b1;
                    end else begin
                        state_d = ST_TRAIL_GUARD;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_TRAIL_GUARD: begin
                period = PERIOD_GUARD;
                if (count_q == GUARD_LAST) begin
                    state_d = ST_TAIL;
                    count_d = '0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_TAIL: begin
                if (count_q == TAIL_LAST) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        if (pktReady) begin
            sent_d = sent_q + 5'd1;
        end
    end

    assign islandActive = (state_q == ST_PREAMBLE) || (state_q == ST_LEAD_GUARD) ||
                          (state_q == ST_PACKET)   || (state_q == ST_TRAIL_GUARD);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sent_q  <= sent_d;
        end
    end

    // Packet contents are captured on the accept clock and held until the next accept.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            header_q     <= '0;
            subpacket0_q <= '0;
            subpacket1_q <= '0;
            subpacket2_q <= '0;
            subpacket3_q <= '0;
        end else if (pktReady) begin
            header_q     <= pktHeader;
            subpacket0_q <= pktSubpacket0;
            subpacket1_q <= pktSubpacket1;
            subpacket2_q <= pktSubpacket2;
            subpacket3_q <= pktSubpacket3;
        end
    end

    // Losing blanking mid-island is flagged but never truncates the island.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            overrun_q <= 1'b0;
        end else if (islandActive && !inBlank) begin
            overrun_q <= 1'b1;
        end
    end

    assign header        = header_q;
    assign subpacket0    = subpacket0_q;
    assign subpacket1    = subpacket1_q;
    assign subpacket2    = subpacket2_q;
    assign subpacket3    = subpacket3_q;
    assign islandOverrun = overrun_q;

`ifdef DATA_ISLAND_STATS_EN
    logic        inBlank_q;
    logic        pktValid_q;
    logic        started_q;
    logic [15:0] islandCount_q, packetCount_q, deferCount_q;
    logic        islandStart;
    logic        blankEnd;

    assign islandStart = (state_q == ST_IDLE) && (state_d == ST_PREAMBLE);
    assign blankEnd    = inBlank_q && !inBlank;

    // A blank counts as deferred when it closes with a packet waiting and no island started in it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            inBlank_q     <= 1'b0;
            pktValid_q    <= 1'b0;
            started_q     <= 1'b0;
            islandCount_q <= '0;
            packetCount_q <= '0;
            deferCount_q  <= '0;
        end else begin
            inBlank_q     <= inBlank;
            pktValid_q    <= pktValid;
            if (blankEnd) begin
                started_q <= islandStart;
            end else if (islandStart) begin
                started_q <= 1'b1;
            end
            islandCount_q <= satInc16(islandCount_q, islandStart);
            packetCount_q <= satInc16(packetCount_q, pktReady);
            deferCount_q  <= satInc16(deferCount_q, blankEnd && pktValid_q && !started_q);
        end
    end

    assign islandCount = islandCount_q;
    assign packetCount = packetCount_q;
    assign deferCount  = deferCount_q;
`endif

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: table of start-decision vectors plus
// hand-sequenced islands checked clock by clock against a small timing model.
module tb_data_island_scheduler;

    typedef struct {
        logic        inBlank;
        logic        pktValid;
        logic [11:0] rem;
        logic [1:0]  expNextPeriod;
    } decision_vec_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        inBlank = 1'b0;
    logic [11:0] blankRemaining = '0;
    logic        pktValid = 1'b0;
    logic        pktReady;
    logic [23:0] pktHeader;
    logic [55:0] pktSubpacket0, pktSubpacket1, pktSubpacket2, pktSubpacket3;
    logic [1:0]  period;
    logic [3:0]  ctl;
    logic        isFirstPacketClock;
    logic [23:0] header;
    logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;
    logic        islandOverrun;
`ifdef DATA_ISLAND_STATS_EN
    logic [15:0] islandCount, packetCount, deferCount;
`endif

    int checks = 0;
    int errors = 0;
    int nextPkt = 0;

    always #5 clock = ~clock;

    function automatic logic [23:0] hdrOf(input int idx);
        return 24'h5A0000 | 24'(idx);
    endfunction

    function automatic logic [55:0] subOf(input int j, input int idx);
        return {8'(j), 16'hBEEF, 32'(idx * 7 + j)};
    endfunction

    assign pktHeader     = hdrOf(nextPkt);
    assign pktSubpacket0 = subOf(0, nextPkt);
    assign pktSubpacket1 = subOf(1, nextPkt);
    assign pktSubpacket2 = subOf(2, nextPkt);
    assign pktSubpacket3 = subOf(3, nextPkt);

    data_island_scheduler dut (
        .clock              (clock),
        .resetN             (resetN),
        .inBlank            (inBlank),
        .blankRemaining     (blankRemaining),
        .pktValid           (pktValid),
        .pktReady           (pktReady),
        .pktHeader          (pktHeader),
        .pktSubpacket0      (pktSubpacket0),
        .pktSubpacket1      (pktSubpacket1),
        .pktSubpacket2      (pktSubpacket2),
        .pktSubpacket3      (pktSubpacket3),
        .period             (period),
        .ctl                (ctl),
        .isFirstPacketClock (isFirstPacketClock),
        .header             (header),
        .subpacket0         (subpacket0),
        .subpacket1         (subpacket1),
        .subpacket2         (subpacket2),
        .subpacket3         (subpacket3),
        .islandOverrun      (islandOverrun)
`ifdef DATA_ISLAND_STATS_EN
        ,
        .islandCount        (islandCount),
        .packetCount        (packetCount),
        .deferCount         (deferCount)
`endif
    );

    task automatic checkOutput(input string name, input int idx,
                               input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic blank, input logic valid, input logic [11:0] rem);
        inBlank        = blank;
        pktValid       = valid;
        blankRemaining = rem;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Expected {pktReady, period, ctl, isFirstPacketClock} at clock k of an island
    // carrying e packets; k=-1 is the IDLE clock that takes the start decision.
    function automatic logic [7:0] expTuple(input int k, input int e);
        int ph;
        int pk;
        if (k < 0) return 8'h00;
        if (k < 8) return {1'b0, 2'd1, 4'b1010, 1'b0};
        if (k < 10) return {(k == 9), 2'd2, 4'b0000, 1'b0};
        if (k < 10 + 32 * e) begin
            ph = (k - 10) % 32;
            pk = (k - 10) / 32;
            return {(ph == 31) && (pk < e - 1), 2'd3, 4'b0000, (ph == 0)};
        end
        if (k < 12 + 32 * e) return {1'b0, 2'd2, 4'b0000, 1'b0};
        return 8'h00;
    endfunction

    // Runs one island from IDLE; blankRemaining counts down each clock and
    // inBlank is forced low from clock dropAt onward to model a cut-short blank.
    task automatic runIsland(input string name, input int nAvail, input int blankLen,
                             input int dropAt, input int expPkts);
        int blankLeft;
        int pending;
        int base;
        int total;
        logic consumed;
        blankLeft = blankLen;
        pending   = nAvail;
        base      = nextPkt;
        total     = 8 + 2 + 32 * expPkts + 2 + 4;
        for (int k = -1; k < total; k++) begin
            applyStimulus((k < dropAt) && (blankLeft > 0), pending > 0, 12'(blankLeft));
            @(negedge clock);
            checkOutput(name, k, 256'({pktReady, period, ctl, isFirstPacketClock}),
                        256'(expTuple(k, expPkts)));
            if (k >= 10 && k < 10 + 32 * expPkts) begin
                checkOutput({name, "-data"}, k,
                            256'({header, subpacket0, subpacket1, subpacket2, subpacket3}),
                            256'({hdrOf(base + (k - 10) / 32),
                                  subOf(0, base + (k - 10) / 32), subOf(1, base + (k - 10) / 32),
                                  subOf(2, base + (k - 10) / 32), subOf(3, base + (k - 10) / 32)}));
            end
            consumed = pktReady;
            nextCycle();
            if (consumed) begin
                nextPkt++;
                pending--;
            end
            if (blankLeft > 0) blankLeft--;
        end
        applyStimulus(1'b0, 1'b0, 12'd0);
        @(negedge clock);
        checkOutput({name, "-idle"}, total, 256'({pktReady, period}), 256'(3'b000));
        nextCycle();
    endtask

    decision_vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 12'd48,   2'd0};
        vecs[1] = '{1'b1, 1'b1, 12'd49,   2'd1};
        vecs[2] = '{1'b1, 1'b1, 12'd47,   2'd0};
        vecs[3] = '{1'b0, 1'b1, 12'd100,  2'd0};
        vecs[4] = '{1'b1, 1'b0, 12'd100,  2'd0};
        vecs[5] = '{1'b1, 1'b1, 12'd4095, 2'd1};
        vecs[6] = '{1'b1, 1'b1, 12'd0,    2'd0};
        vecs[7] = '{1'b1, 1'b1, 12'd200,  2'd1};

        // Reset state.
        #12;
        checkOutput("reset-outputs", 0,
                    256'({pktReady, period, ctl, isFirstPacketClock, islandOverrun, header}), 256'(0));
        checkOutput("reset-subpackets", 0,
                    256'({subpacket0, subpacket1, subpacket2, subpacket3}), 256'(0));
        resetN = 1'b1;
        nextCycle();

        // Start decision boundaries, one vector per trip through IDLE.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].inBlank, vecs[i].pktValid, vecs[i].rem);
            @(negedge clock);
            checkOutput("decision-idle", i, 256'({pktReady, period}), 256'(3'b000));
            nextCycle();
            @(negedge clock);
            checkOutput("decision-next", i, 256'({pktReady, period}), 256'({1'b0, vecs[i].expNextPeriod}));
            resetN = 1'b0;
            #1;
            resetN = 1'b1;
            applyStimulus(1'b0, 1'b0, 12'd0);
            nextCycle();
        end

        runIsland("single", 1, 100, 100000, 1);
        checkOutput("no-overrun", 0, 256'(islandOverrun), 256'(0));
        runIsland("three", 3, 200, 100000, 3);
        runIsland("max18", 20, 1000, 100000, 18);
        runIsland("left2", 2, 100, 100000, 2);
        checkOutput("no-overrun", 1, 256'(islandOverrun), 256'(0));

        runIsland("overrun", 3, 500, 50, 2);
        checkOutput("overrun-set", 0, 256'(islandOverrun), 256'(1));
        applyStimulus(1'b1, 1'b0, 12'd300);
        repeat (5) nextCycle();
        checkOutput("overrun-sticky", 0, 256'(islandOverrun), 256'(1));

        // Asynchronous reset in the middle of a packet (phase 10).
        applyStimulus(1'b1, 1'b1, 12'd100);
        repeat (21) nextCycle();
        checkOutput("mid-packet", 0, 256'({period, isFirstPacketClock}), 256'({2'd3, 1'b0}));
        @(negedge clock);
        resetN = 1'b0;
        #1;
        checkOutput("async-reset", 0,
                    256'({pktReady, period, ctl, isFirstPacketClock, islandOverrun}), 256'(0));
        @(posedge clock);
        #1;
        checkOutput("reset-edge", 0, 256'({pktReady, period, isFirstPacketClock}), 256'(0));
        applyStimulus(1'b0, 1'b0, 12'd0);
        resetN = 1'b1;
        nextCycle();
        @(negedge clock);
        checkOutput("post-reset-idle", 0, 256'({pktReady, period, islandOverrun, header}), 256'(0));
        nextCycle();

        runIsland("after-reset", 1, 60, 100000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
